// File: rtl/sr_latch_bank.sv
// Multi-channel state-holding bank: async global reset, async per-channel set,
// masked addressed write into latch (MODE 0) or posedge-flop (MODE 1) storage.
module sr_latch_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RSTB,
  input  logic [CHANNELS-1:0]       SETB,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH-1:0]          wr_mask,
  input  logic                      clr_flags,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] qn,
  output logic [CHANNELS-1:0]       set_seen,
  output logic [CNT_W-1:0]          wr_count
);

  logic [CHANNELS-1:0] hit;
  logic                wr_acc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] seen_q, seen_d;

  // Per-channel write decode; an out-of-range wr_ch matches no channel.
  always_comb begin
    hit = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      hit[c] = wr_en && RSTB && SETB[c] && (wr_ch == CH_W'(c));
    end
  end

  assign wr_acc = |hit;

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic ovr;
    // Both async controls low forces q and qn low together, like the cell.
    assign ovr = !RSTB && !SETB[c];

    if (MODE == 0) begin : g_latch
      for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
        logic bit_q;

        always_latch begin
          if (!RSTB) begin
            bit_q <= 1'b0;
          end else if (!SETB[c]) begin
            bit_q <= 1'b1;
          end else if (CLK && hit[c] && wr_mask[b]) begin
            bit_q <= wr_data[b];
          end
        end

        assign q[c*WIDTH + b]  = bit_q;
        assign qn[c*WIDTH + b] = !ovr && !bit_q;
      end
    end else begin : g_flop
      logic             set_n;
      logic [WIDTH-1:0] ch_q, ch_d;

      // Set edge also fires when RSTB releases while SETB[c] is still held.
      assign set_n = SETB[c] | ~RSTB;

      always_comb begin
        ch_d = ch_q;
        if (hit[c]) begin
          ch_d = (ch_q & ~wr_mask) | (wr_data & wr_mask);
        end
      end

      always_ff @(posedge CLK or negedge RSTB or negedge set_n) begin
        if (!RSTB) begin
          ch_q <= '0;
        end else if (!set_n) begin
          ch_q <= '1;
        end else begin
          ch_q <= ch_d;
        end
      end

      assign q[c*WIDTH +: WIDTH]  = ch_q;
      assign qn[c*WIDTH +: WIDTH] = ovr ? '0 : ~ch_q;
    end
  end

  // Saturating accepted-write counter and sticky set flags (set beats clear).
  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    seen_d = seen_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!SETB[c]) begin
        seen_d[c] = 1'b1;
      end else if (clr_flags) begin
        seen_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cnt_q  <= '0;
      seen_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  assign wr_count = cnt_q;
  assign set_seen = seen_q;

endmodule
